spu_issue_ctrl: RTL
===================

Name: spu_issue_ctrl

Overview:
- Central stall/issue controller for the dual-issue SPU front end. It merges per-stage stall requests, multi-cycle hold requests and branch flushes into the 13-bit stall vector that drives PC, IF/ID and all downstream pipeline registers.
- It detects same-pipe instruction pairs (even/even, odd/odd) and sequences them as two single issues through a split state.
- It sits between the stage datapaths and every pipeline buffer.

Parameters:
- STAGES, 13, width of stall vector; bit 0 = PC, bit 1 = IF/ID, bit 2 = ID/EX, bits 3..12 = downstream stage registers.
- HOLD_W, 4, width of multi-cycle hold length.

Ports:
- clk  in  1  SPU clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  fetch not ready (level)
- stallreq_id  in  1  ID data hazard (level)
- stallreq_ex  in  1  EX structural busy (level)
- hold_start  in  1  pulse: start multi-cycle ID hold
- hold_len  in  HOLD_W  hold length in cycles, sampled with hold_start
- pair_valid  in  1  ID holds a valid 2-instruction pair
- pipe_l  in  1  pipe of lower instruction (0 even, 1 odd)
- pipe_h  in  1  pipe of upper instruction (0 even, 1 odd)
- flush_req  in  1  branch taken / redirect
- stall  out  [0:STAGES-1]  stall vector, bit 0 = MSB, 1 = STOP
- split_issue  out  1  IF/ID must replay upper instruction alone next cycle
- flush  out  1  clear IF/ID and ID/EX
- busy  out  1  controller in HOLD or SPLIT

Behaviour:
- Reset: state=RUN, hold counter=0; outputs stall=0, split_issue=0, flush=0, busy=0. Reset mid-HOLD or mid-SPLIT aborts immediately to RUN.
- Outputs are combinational from state plus current requests; state and counter update on posedge clk.
- Stall masks: MASK(k) = bits 0..k STOP, others NOSTOP. IF request -> MASK(1) (bubble into ID). ID request or HOLD -> MASK(2). EX request -> MASK(3). Split -> MASK(1) with split_issue=1 (replay, not bubble).
- Priority, highest first: flush_req > stallreq_ex > HOLD/stallreq_id > split > stallreq_if. The stall output is the mask of the highest active source only.
- flush_req:
  - flush=1, stall=0.
  - Next state RUN, counter cleared.
  - A pending split is cancelled.
- States:
  - RUN:
    - hold_start with hold_len>0 -> HOLD, counter=hold_len-1, stall=MASK(2) this cycle. hold_len=0 is ignored.
    - Otherwise, if pair_valid and pipe_l==pipe_h and no higher-priority request -> split_issue=1, stall=MASK(1), next SPLIT.
    - Otherwise requests map directly to masks, no state change.
  - SPLIT:
    - ID issues upper instruction alone.
    - split_issue=0; conflict check suppressed this cycle.
    - stall from EX/ID/IF requests as usual.
    - Next RUN unless stallreq_ex or stallreq_id holds the pipe, in which case stay SPLIT.
  - HOLD:
    - stall=MASK(2) (or MASK(3) if stallreq_ex).
    - Counter decrements each cycle. At counter==0, next RUN.
    - A new hold_start while in HOLD reloads the counter with max(remaining, hold_len-1).
- busy = (state != RUN).
- Simultaneous split condition and stallreq_id in RUN: the ID stall wins. Split is re-evaluated next cycle with the same pair.

Optional Feature:
- ISSUE_STATS_EN:
  - With it: adds outputs split_cnt[31:0] and stall_cnt[31:0]. split_cnt increments on each RUN->SPLIT transition. stall_cnt increments each cycle stall[0]==STOP. Both reset to 0 and wrap at 2^32.
  - Without it: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle, pair_valid=1, pipe_l=0, pipe_h=1 -> stall=13'h0000, split_issue=0, busy=0 every cycle.
- pair_valid=1, pipe_l=pipe_h=1 (odd/odd) -> cycle n: stall bits0..1 STOP (13'h1800), split_issue=1. Cycle n+1: state SPLIT, stall=0, split_issue=0. Cycle n+2: RUN.
- hold_start with hold_len=3 -> stall=13'h1C00 for exactly 3 cycles, busy=1 for cycles 2..3, then stall=0.
- stallreq_ex=1 concurrent with stallreq_id=1 and even/even pair -> stall=13'h1E00, split_issue=0. After ex drops, ID mask, then split.
- flush_req in HOLD with counter=5 -> same cycle flush=1, stall=0. Next cycle RUN, busy=0.
- rst asserted while in SPLIT -> next cycle all outputs 0, state RUN. With ISSUE_STATS_EN, counters read 0.

Source files
------------

// File: rtl/spu_issue_ctrl.sv
// Stall/issue controller for the dual-issue SPU front end.
// Optional macro ISSUE_STATS_EN adds split_cnt and stall_cnt outputs.
module spu_issue_ctrl #(
  parameter int STAGES = 13,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              hold_start,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              pair_valid,
  input  logic              pipe_l,
  input  logic              pipe_h,
  input  logic              flush_req,
  output logic [0:STAGES-1] stall,
  output logic              split_issue,
  output logic              flush,
  output logic              busy
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]       split_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    SPLIT = 2'd2
  } state_t;

  function automatic logic [0:STAGES-1] mask(input int k);
    logic [0:STAGES-1] m;
    for (int i = 0; i < STAGES; i++) begin
      m[i] = (i <= k);
    end
    return m;
  endfunction

  localparam logic [0:STAGES-1] MASK1 = mask(1);
  localparam logic [0:STAGES-1] MASK2 = mask(2);
  localparam logic [0:STAGES-1] MASK3 = mask(3);

  state_t            state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [HOLD_W-1:0] rem, new_len, hold_nxt;
  logic              same_pipe, hold_req;
  logic              hold_src, split_src;
  logic              sel_ex, sel_id, sel_sp, sel_if;

  assign same_pipe = pair_valid && (pipe_l == pipe_h);
  assign hold_req  = hold_start && (hold_len != '0);
  assign rem       = cnt - HOLD_W'(1);
  assign new_len   = hold_len - HOLD_W'(1);
  assign hold_src  = (state == HOLD) || ((state == RUN) && hold_req);
  assign split_src = (state == RUN) && same_pipe;

  // One-hot source select so the decoder below stays unique.
  assign sel_ex = stallreq_ex;
  assign sel_id = !sel_ex && (hold_src || stallreq_id);
  assign sel_sp = !sel_ex && !sel_id && split_src;
  assign sel_if = !sel_ex && !sel_id && !sel_sp && stallreq_if;

  // A reload never shortens the hold already in progress.
  assign hold_nxt = (hold_req && (new_len > rem)) ? new_len : rem;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall       = '0;
    split_issue = 1'b0;
    flush       = 1'b0;
    if (rst) begin
      state_n = RUN;
      cnt_n   = '0;
    end else if (flush_req) begin
      flush   = 1'b1;
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (hold_req) begin
            cnt_n   = new_len;
            state_n = (new_len != '0) ? HOLD : RUN;
          end else if (same_pipe && !stallreq_ex && !stallreq_id) begin
            state_n = SPLIT;
          end
        end
        HOLD: begin
          cnt_n   = hold_nxt;
          state_n = (hold_nxt != '0) ? HOLD : RUN;
        end
        SPLIT: begin
          state_n = (stallreq_ex || stallreq_id) ? SPLIT : RUN;
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
      unique case (1'b1)
        sel_ex: stall = MASK3;
        sel_id: stall = MASK2;
        sel_sp: begin
          stall       = MASK1;
          split_issue = 1'b1;
        end
        sel_if: stall = MASK1;
        default: stall = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign busy = !rst && (state != RUN);

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      split_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state == RUN) && (state_n == SPLIT)) begin
        split_cnt <= split_cnt + 32'd1;
      end
      if (stall[0]) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
